// File: rtl/pp3_pad_filter.sv
// pp3_pad_filter
// Input conditioning for a PP3 pad. It takes the O output of an input-mode
// SYN_PAD, brings that asynchronous level into the IQC domain, and rejects
// glitches. A new level reaches Q only after the synchronised level has
// differed from Q on FILTER_CYCLES consecutive enabled edges.
//
// Ports
//   IQC  : clock, rising edge
//   IQR  : synchronous active-high reset (takes priority over IQE)
//   IQE  : filter enable; when low, the FSM, counter and Q hold and the
//          strobes are 0. The synchroniser keeps shifting.
//   I    : raw pad level, asynchronous to IQC
//   Q    : filtered, synchronised level, driven straight from one flop
//   RISE : one-cycle strobe in the cycle where Q has just gone 0->1
//   FALL : one-cycle strobe in the cycle where Q has just gone 1->0
//
// Build option
//   PP3_PAD_FILTER_EDGE_EN : when defined, the RISE/FALL strobe flops are
//   built. When undefined, RISE and FALL are tied to 0 and no strobe flops
//   exist. Q behaves the same in both builds.
module pp3_pad_filter #(
  parameter int   SYNC_STAGES   = 2,    // 2..4
  parameter int   FILTER_CYCLES = 4,    // 1..255
  parameter logic INIT          = 1'b0
) (
  input  logic IQC,
  input  logic IQR,
  input  logic IQE,
  input  logic I,
  output logic Q,
  output logic RISE,
  output logic FALL
);

  localparam int CNT_W = $clog2(FILTER_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FILTER_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(FILTER_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic {
    STEADY  = 1'b0,
    QUALIFY = 1'b1
  } state_t;

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  state_t                 state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   q_q, q_d;
  logic                   s;

  // Synchroniser: shifts on every edge, whatever IQE is doing.
  assign sync_d = {sync_q[SYNC_STAGES-2:0], I};
  assign s      = sync_q[SYNC_STAGES-1];

  // Qualification FSM. Nothing moves on an edge where IQE is low, so a
  // qualification run counts only enabled edges and resumes where it left off.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    q_d     = q_q;
    if (IQE) begin
      case (state_q)
        STEADY: begin
          cnt_d = '0;
          if (s != q_q) begin
            if (FILTER_CYCLES == 1) begin
              q_d = s;
            end else begin
              state_d = QUALIFY;
              cnt_d   = CNT_ONE;
            end
          end
        end
        QUALIFY: begin
          if (s == q_q) begin
            // Level came back before qualifying: drop the run silently.
            state_d = STEADY;
            cnt_d   = '0;
          end else if (cnt_q == CNT_LAST) begin
            q_d     = s;
            cnt_d   = '0;
            state_d = STEADY;
          end else if (cnt_q != CNT_MAX) begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end
        default: begin
          state_d = STEADY;
          cnt_d   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge IQC) begin
    if (IQR) begin
      sync_q  <= {SYNC_STAGES{INIT}};
      state_q <= STEADY;
      cnt_q   <= '0;
      q_q     <= INIT;
    end else begin
      sync_q  <= sync_d;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      q_q     <= q_d;
    end
  end

  assign Q = q_q;

`ifdef PP3_PAD_FILTER_EDGE_EN
  logic rise_q, rise_d;
  logic fall_q, fall_d;

  // Strobes are registered next to Q, so they are high exactly in the cycle
  // where Q shows its new value. Reset never produces a strobe.
  always_comb begin
    rise_d = IQE & q_d & ~q_q;
    fall_d = IQE & ~q_d & q_q;
  end

  always_ff @(posedge IQC) begin
    if (IQR) begin
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      rise_q <= rise_d;
      fall_q <= fall_d;
    end
  end

  assign RISE = rise_q;
  assign FALL = fall_q;
`else
  assign RISE = 1'b0;
  assign FALL = 1'b0;
`endif

endmodule

// File: tb/tb_pp3_pad_filter.sv
module tb_pp3_pad_filter;

`ifdef PP3_PAD_FILTER_EDGE_EN
  localparam bit EDGE_EN = 1'b1;
`else
  localparam bit EDGE_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic iqr = 1'b1;
  logic iqe = 1'b1;
  logic i   = 1'b0;
  logic q, rise, fall;
  logic q1, rise1, fall1;

  always #5 clk = ~clk;

  // Default configuration: SYNC_STAGES=2, FILTER_CYCLES=4, INIT=0.
  pp3_pad_filter #(.SYNC_STAGES(2), .FILTER_CYCLES(4), .INIT(1'b0)) dut (
    .IQC(clk), .IQR(iqr), .IQE(iqe), .I(i), .Q(q), .RISE(rise), .FALL(fall)
  );

  // Single-cycle qualification: Q follows S with SYNC_STAGES+1 edges latency.
  pp3_pad_filter #(.SYNC_STAGES(2), .FILTER_CYCLES(1), .INIT(1'b0)) dut1 (
    .IQC(clk), .IQR(iqr), .IQE(iqe), .I(i), .Q(q1), .RISE(rise1), .FALL(fall1)
  );

  typedef struct {
    logic iqr;
    logic iqe;
    logic i;
    logic q;
    logic rise;
    logic fall;
  } vec_t;

  typedef struct {
    logic q;
    logic rise;
    logic fall;
    logic q1;
    logic rise1;
    logic fall1;
  } exp_t;

  vec_t tab[$];
  exp_t sb[$];
  exp_t e;
  exp_t got;
  int   checks = 0;
  int   errors = 0;

  // Reference for the FILTER_CYCLES=1 instance.
  logic m_s0, m_s1, m_q, m_r, m_f, nq;

  task automatic add(input int n, input logic r, input logic en, input logic lvl,
                     input logic eq, input logic er, input logic ef);
    vec_t v;
    v.iqr = r; v.iqe = en; v.i = lvl; v.q = eq; v.rise = er; v.fall = ef;
    for (int k = 0; k < n; k++) tab.push_back(v);
  endtask

  task automatic chk(input string name, input int idx, input logic act, input logic req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s vec %0d got %b want %b", name, idx, act, req);
    end
  endtask

  initial begin
    // fields: count, IQR, IQE, I, expected Q, RISE, FALL (after the edge)
    // Reset held 2 edges with I=1, then Q rises on the 6th edge after release.
    add(2, 1, 1, 1, 0, 0, 0);
    add(5, 0, 1, 1, 0, 0, 0);
    add(1, 0, 1, 1, 1, 1, 0);
    add(4, 0, 1, 1, 1, 0, 0);
    // Qualified falling level.
    add(5, 0, 1, 0, 1, 0, 0);
    add(1, 0, 1, 0, 0, 0, 1);
    add(3, 0, 1, 0, 0, 0, 0);
    // 3-cycle glitch is rejected.
    add(3, 0, 1, 1, 0, 0, 0);
    add(8, 0, 1, 0, 0, 0, 0);
    // 4-cycle pulse qualifies: rise on 6th edge, fall 6 edges after I fell.
    add(4, 0, 1, 1, 0, 0, 0);
    add(1, 0, 1, 0, 0, 0, 0);
    add(1, 0, 1, 0, 1, 1, 0);
    add(3, 0, 1, 0, 1, 0, 0);
    add(1, 0, 1, 0, 0, 0, 1);
    add(3, 0, 1, 0, 0, 0, 0);
    // Enable freeze mid-qualification: resumes from held count.
    add(4, 0, 1, 1, 0, 0, 0);
    add(5, 0, 0, 1, 0, 0, 0);
    add(1, 0, 1, 1, 0, 0, 0);
    add(1, 0, 1, 1, 1, 1, 0);
    add(2, 0, 1, 1, 1, 0, 0);
    // Freeze in STEADY while the level drops: needs 4 enabled edges after.
    add(8, 0, 0, 0, 1, 0, 0);
    add(3, 0, 1, 0, 1, 0, 0);
    add(1, 0, 1, 0, 0, 0, 1);
    add(2, 0, 1, 0, 0, 0, 0);
    // Reset at CNT=2 (with IQE low: reset wins), then requalify.
    add(4, 0, 1, 1, 0, 0, 0);
    add(1, 1, 0, 1, 0, 0, 0);
    add(5, 0, 1, 1, 0, 0, 0);
    add(1, 0, 1, 1, 1, 1, 0);
    add(2, 0, 1, 1, 1, 0, 0);
    // Reset while Q=1: Q returns to INIT without a FALL strobe.
    add(1, 1, 1, 1, 0, 0, 0);
    add(5, 0, 1, 1, 0, 0, 0);
    add(1, 0, 1, 1, 1, 1, 0);
    add(2, 0, 1, 1, 1, 0, 0);

    m_s0 = 1'b0; m_s1 = 1'b0; m_q = 1'b0; m_r = 1'b0; m_f = 1'b0;

    for (int k = 0; k < tab.size(); k++) begin
      @(negedge clk);
      iqr = tab[k].iqr;
      iqe = tab[k].iqe;
      i   = tab[k].i;

      if (iqr) begin
        m_s0 = 1'b0; m_s1 = 1'b0; m_q = 1'b0; m_r = 1'b0; m_f = 1'b0;
      end else begin
        if (iqe) begin
          nq  = m_s1;
          m_r = nq & ~m_q;
          m_f = ~nq & m_q;
          m_q = nq;
        end else begin
          m_r = 1'b0;
          m_f = 1'b0;
        end
        m_s1 = m_s0;
        m_s0 = i;
      end

      e.q     = tab[k].q;
      e.rise  = EDGE_EN & tab[k].rise;
      e.fall  = EDGE_EN & tab[k].fall;
      e.q1    = m_q;
      e.rise1 = EDGE_EN & m_r;
      e.fall1 = EDGE_EN & m_f;
      sb.push_back(e);

      @(posedge clk);
      #1;
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL scoreboard vec %0d got empty want entry", k);
      end else begin
        got = sb.pop_front();
        chk("q",     k, q,     got.q);
        chk("rise",  k, rise,  got.rise);
        chk("fall",  k, fall,  got.fall);
        chk("q1",    k, q1,    got.q1);
        chk("rise1", k, rise1, got.rise1);
        chk("fall1", k, fall1, got.fall1);
        checks++;
        if ((rise & fall) !== 1'b0) begin
          errors++;
          $display("FAIL rise_fall_excl vec %0d got %b%b want not both", k, rise, fall);
        end
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
